// File: rtl/prod_acc_pkg.sv
// Shared types and helpers for the product accumulator stage.
// Termination rule lives here so the RTL and any future users agree on it.
package prod_acc_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // cnt is the beat count including the beat being accepted; cmax forces a close
    function automatic logic is_term(input logic        last,
                                     input int unsigned cnt,
                                     input int unsigned len,
                                     input int unsigned cmax);
        return last || ((len != 0) && (cnt == len)) || (cnt == cmax);
    endfunction

endpackage

// File: rtl/prod_acc_if.sv
// Stream bundle between the multiplier array, the accumulator and its consumer.
interface prod_acc_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
);
    logic [LEN_W-1:0]  cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [LEN_W-1:0]  out_count;
    logic              out_ovf;

    modport slave (
        input  cfg_len, in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output cfg_len, in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/prod_acc_sat_add.sv
// Accumulator adder: acc + zero-extended operand, with optional clamp at all-ones.
module sat_add #(
    parameter int ACC_W = 24,
    parameter int OP_W  = 16,
    parameter bit SAT   = 1'b1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [OP_W-1:0]  b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);
    logic [ACC_W:0] full;

    always_comb begin
        full  = {1'b0, a} + {{(ACC_W + 1 - OP_W){1'b0}}, b};
        carry = full[ACC_W];
        sum   = (SAT && carry) ? {ACC_W{1'b1}} : full[ACC_W-1:0];
    end
endmodule

// File: rtl/prod_accumulator.sv
// Sums each packet of multiplier products into one wide result with valid/ready on both sides.
//   state | meaning
//   IDLE  | no packet open; next accepted beat starts one
//   ACCUM | packet open, summing beats
//   HOLD  | result presented; a beat accepted with the handoff opens the next packet
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter bit SAT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    prod_acc_if.slave   bus
);
    localparam int unsigned CNT_MAX = (2 ** LEN_W) - 1;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic [LEN_W-1:0]   len_q, len_nxt;
    logic               ovf, ovf_nxt;
    logic               rdy_en;

    logic               rdy;
    logic               accept;
    logic               start;
    logic               term;
    logic [ACC_W-1:0]   add_a;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [LEN_W-1:0]   cnt_inc;
    logic [LEN_W-1:0]   len_eff;

    // rdy_en keeps in_ready low through the reset cycle itself
    always_comb begin
        rdy = 1'b0;
        case (state)
            IDLE:    rdy = rdy_en;
            ACCUM:   rdy = 1'b1;
            HOLD:    rdy = bus.out_ready;
            default: rdy = 1'b0;
        endcase
    end

    assign accept  = bus.in_valid && rdy;
    assign start   = accept && (state != ACCUM);
    assign add_a   = start ? '0 : acc;
    assign cnt_inc = start ? LEN_W'(1) : cnt + LEN_W'(1);
    assign len_eff = start ? bus.cfg_len : len_q;
    assign term    = is_term(bus.in_last, 32'(cnt_inc), 32'(len_eff), CNT_MAX);

    sat_add #(
        .ACC_W (ACC_W),
        .OP_W  (PROD_W),
        .SAT   (SAT)
    ) u_add (
        .a     (add_a),
        .b     (bus.in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        ovf_nxt   = ovf;
        if (accept) begin
            acc_nxt   = add_sum;
            cnt_nxt   = cnt_inc;
            len_nxt   = len_eff;
            ovf_nxt   = start ? 1'b0 : (ovf || add_carry);
            state_nxt = term ? HOLD : ACCUM;
        end else if ((state == HOLD) && bus.out_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            len_q  <= '0;
            ovf    <= 1'b0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            len_q  <= len_nxt;
            ovf    <= ovf_nxt;
            rdy_en <= 1'b1;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = acc;
    assign bus.out_count = cnt;
    assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed and throttled-stream bench for prod_accumulator; three instances share one
// input stream: 24-bit saturating, 17-bit saturating and 17-bit wrapping.
module tb_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;
    int drv_beats;
    int drv_cycles;

    typedef struct {
        longint s24;
        longint ss;
        longint sw;
        int     cnt;
        bit     o24;
        bit     os;
        bit     ow;
    } exp_t;
    exp_t expq[$];

    always #5 clk = ~clk;

    prod_acc_if #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) ifm ();
    prod_acc_if #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) ifs ();
    prod_acc_if #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) ifw ();

    assign ifm.cfg_len = cfg_len;  assign ifm.in_valid = in_valid;  assign ifm.in_prod = in_prod;
    assign ifm.in_last = in_last;  assign ifm.out_ready = out_ready;
    assign ifs.cfg_len = cfg_len;  assign ifs.in_valid = in_valid;  assign ifs.in_prod = in_prod;
    assign ifs.in_last = in_last;  assign ifs.out_ready = out_ready;
    assign ifw.cfg_len = cfg_len;  assign ifw.in_valid = in_valid;  assign ifw.in_prod = in_prod;
    assign ifw.in_last = in_last;  assign ifw.out_ready = out_ready;

    prod_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8), .SAT(1'b1)) dut     (.clk(clk), .rst(rst), .bus(ifm));
    prod_accumulator #(.PROD_W(16), .ACC_W(17), .LEN_W(8), .SAT(1'b1)) dut_s17 (.clk(clk), .rst(rst), .bus(ifs));
    prod_accumulator #(.PROD_W(16), .ACC_W(17), .LEN_W(8), .SAT(1'b0)) dut_w17 (.clk(clk), .rst(rst), .bus(ifw));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // returns one time unit after the accepting edge
    task automatic send_beat(input logic [15:0] p, input logic l);
        int n  = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        while (!ok && n < 50) begin
            #1;
            ok = ifm.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check_val("send_accept", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [31:0] s,
                               input logic [31:0] c, input logic [31:0] o);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!ifm.out_valid && n < 50) begin
            step();
            n++;
        end
        check_val({tag, "_vld"}, 32'(ifm.out_valid), 32'd1);
        check_val({tag, "_sum"}, 32'(ifm.out_sum), s);
        check_val({tag, "_cnt"}, 32'(ifm.out_count), c);
        check_val({tag, "_ovf"}, 32'(ifm.out_ovf), o);
        step();
        out_ready = 1'b0;
        check_val({tag, "_drop"}, 32'(ifm.out_valid), 32'd0);
    endtask

    task automatic drive_pkts(input int npkt, input int pv);
        int     done  = 0;
        int     guard = 0;
        bit     first = 1'b1;
        bit     acc;
        bit     term;
        longint t;
        exp_t   m;
        int     mlen = 0;
        drv_beats  = 0;
        drv_cycles = 0;
        cfg_len = 8'($urandom_range(6));
        m = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        while (done < npkt && guard < 40000) begin
            in_valid = ($urandom_range(99) < pv);
            in_prod  = ($urandom_range(2) == 0) ? 16'hFFFF : 16'($urandom);
            in_last  = ($urandom_range(3) == 0);
            #1;
            acc = in_valid && ifm.in_ready;
            @(posedge clk);
            #1;
            guard++;
            drv_cycles++;
            if (acc) begin
                drv_beats++;
                if (first) begin
                    m = '{longint'(in_prod), longint'(in_prod), longint'(in_prod), 1, 1'b0, 1'b0, 1'b0};
                    mlen = int'(cfg_len);
                end else begin
                    t = m.s24 + longint'(in_prod);
                    if (t > 64'hFFFFFF) begin m.s24 = 64'hFFFFFF; m.o24 = 1'b1; end else m.s24 = t;
                    t = m.ss + longint'(in_prod);
                    if (t > 64'h1FFFF) begin m.ss = 64'h1FFFF; m.os = 1'b1; end else m.ss = t;
                    t = m.sw + longint'(in_prod);
                    if (t > 64'h1FFFF) m.ow = 1'b1;
                    m.sw = t & 64'h1FFFF;
                    m.cnt++;
                end
                term = in_last || (mlen != 0 && m.cnt == mlen) || (m.cnt == 255);
                first = term;
                if (term) begin
                    expq.push_back(m);
                    done++;
                    cfg_len = 8'($urandom_range(6));
                end
            end
        end
        in_valid = 1'b0;
        if (done < npkt) check_val("drv_timeout", 32'(done), 32'(npkt));
    endtask

    task automatic monitor_pkts(input int npkt, input int pr);
        int   got   = 0;
        int   guard = 0;
        exp_t e;
        while (got < npkt && guard < 60000) begin
            out_ready = ($urandom_range(99) < pr);
            #1;
            if (ifm.out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check_val("rnd_queue", 32'd0, 32'd1);
                end else begin
                    e = expq.pop_front();
                    check_val("rnd_sum24", 32'(ifm.out_sum), 32'(e.s24));
                    check_val("rnd_cnt",   32'(ifm.out_count), 32'(e.cnt));
                    check_val("rnd_ovf24", 32'(ifm.out_ovf), 32'(e.o24));
                    check_val("rnd_sum17s", 32'(ifs.out_sum), 32'(e.ss));
                    check_val("rnd_ovf17s", 32'(ifs.out_ovf), 32'(e.os));
                    check_val("rnd_sum17w", 32'(ifw.out_sum), 32'(e.sw));
                    check_val("rnd_ovf17w", 32'(ifw.out_ovf), 32'(e.ow));
                end
                got++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b0;
        if (got < npkt) check_val("mon_timeout", 32'(got), 32'(npkt));
    endtask

    task automatic run_traffic(input int npkt, input int pv, input int pr);
        fork
            drive_pkts(npkt, pv);
            monitor_pkts(npkt, pr);
        join
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_len = '0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        check_val("rst_in_ready", 32'(ifm.in_ready), 32'd0);
        check_val("rst_out_valid", 32'(ifm.out_valid), 32'd0);
        check_val("rst_out_sum", 32'(ifm.out_sum), 32'd0);
        check_val("rst_out_count", 32'(ifm.out_count), 32'd0);
        check_val("rst_out_ovf", 32'(ifm.out_ovf), 32'd0);
        rst = 1'b0;
        step();
        check_val("post_rst_ready", 32'(ifm.in_ready), 32'd1);

        // abort a partial packet with a 3-cycle reset
        send_beat(16'h0100, 1'b0);
        send_beat(16'h0100, 1'b0);
        rst = 1'b1;
        repeat (3) begin
            step();
            check_val("t1_rst_vld", 32'(ifm.out_valid), 32'd0);
            check_val("t1_rst_rdy", 32'(ifm.in_ready), 32'd0);
        end
        rst = 1'b0;
        send_beat(16'h0003, 1'b1);
        take_result("t1", 32'h3, 32'd1, 32'd0);

        // terminate on last only
        send_beat(16'h0010, 1'b0);
        send_beat(16'h0020, 1'b0);
        check_val("t2_mid_vld", 32'(ifm.out_valid), 32'd0);
        send_beat(16'h0030, 1'b1);
        check_val("t2_lat", 32'(ifm.out_valid), 32'd1);
        take_result("t2", 32'h60, 32'd3, 32'd0);

        // terminate on length, then a short packet by last
        cfg_len = 8'd4;
        repeat (4) send_beat(16'hFFFF, 1'b0);
        check_val("t3_lat", 32'(ifm.out_valid), 32'd1);
        take_result("t3a", 32'h3FFFC, 32'd4, 32'd0);
        send_beat(16'h0042, 1'b1);
        take_result("t3b", 32'h42, 32'd1, 32'd0);

        // overflow at 17 bits: clamp vs wrap
        cfg_len = 8'd0;
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'hFFFF, 1'b1);
        check_val("t4_sat_sum", 32'(ifs.out_sum), 32'h1FFFF);
        check_val("t4_sat_ovf", 32'(ifs.out_ovf), 32'd1);
        check_val("t4_wrap_sum", 32'(ifw.out_sum), 32'h0FFFD);
        check_val("t4_wrap_ovf", 32'(ifw.out_ovf), 32'd1);
        take_result("t4_24", 32'h2FFFD, 32'd3, 32'd0);

        // forced close at 255 beats
        repeat (254) send_beat(16'h0001, 1'b0);
        check_val("t4b_open", 32'(ifm.out_valid), 32'd0);
        send_beat(16'h0001, 1'b0);
        take_result("t4b", 32'd255, 32'd255, 32'd0);

        // backpressure in HOLD, then handoff with a coincident new beat
        send_beat(16'h0007, 1'b1);
        in_valid = 1'b1; in_prod = 16'h0005; in_last = 1'b1;
        repeat (5) begin
            step();
            check_val("t5_rdy", 32'(ifm.in_ready), 32'd0);
            check_val("t5_vld", 32'(ifm.out_valid), 32'd1);
            check_val("t5_sum", 32'(ifm.out_sum), 32'h7);
            check_val("t5_cnt", 32'(ifm.out_count), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check_val("t5_rdy_up", 32'(ifm.in_ready), 32'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check_val("t5_next_vld", 32'(ifm.out_valid), 32'd1);
        check_val("t5_next_sum", 32'(ifm.out_sum), 32'h5);
        take_result("t5b", 32'h5, 32'd1, 32'd0);

        // throttled stream against the model, then full-rate streaming
        run_traffic(1000, 70, 60);
        check_val("rnd_leftover", 32'(expq.size()), 32'd0);
        run_traffic(20, 100, 100);
        check_val("thruput", 32'(drv_cycles), 32'(drv_beats));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
